// File: rtl/caf_ref_pkg.sv
// Shared types and constants for the CAF reference-buffer reader.
// Holds the reader FSM encoding, the sample record and the skid FIFO depth.
package caf_ref_pkg;

  localparam int REF_FIFO_DEPTH = 2;
  localparam int REF_I_BITS     = 12;
  localparam int REF_Q_BITS     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ref_state_t;

  typedef struct packed {
    logic                         last;
    logic signed [REF_I_BITS-1:0] i;
    logic signed [REF_Q_BITS-1:0] q;
  } ref_sample_t;

endpackage

// File: rtl/reference_reader_fifo.sv
// Small synchronous FIFO (REF_FIFO_DEPTH entries) with occupancy count.
// Push and pop may coincide, including when full.
module reference_reader_fifo
  import caf_ref_pkg::*;
#(
  parameter int width = 25
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   push,
  input  logic [width-1:0]                       wr_data,
  input  logic                                   pop,
  output logic [width-1:0]                       rd_data,
  output logic [$clog2(REF_FIFO_DEPTH+1)-1:0]    count,
  output logic                                   empty
);

  localparam int ptr_bits = (REF_FIFO_DEPTH > 1) ? $clog2(REF_FIFO_DEPTH) : 1;
  localparam int cnt_w    = $clog2(REF_FIFO_DEPTH+1);
  localparam logic [ptr_bits-1:0] last_slot = ptr_bits'(REF_FIFO_DEPTH-1);

  logic [width-1:0]    mem [REF_FIFO_DEPTH];
  logic [ptr_bits-1:0] wr_ptr;
  logic [ptr_bits-1:0] rd_ptr;
  logic                do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage is reset as well so the downstream data outputs read 0
  // out of reset; at this depth it costs a handful of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REF_FIFO_DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == last_slot) ? '0 : wr_ptr + ptr_bits'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == last_slot) ? '0 : rd_ptr + ptr_bits'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reference_reader.sv
// Read initiator sweeping the reference I/Q buffer and streaming samples to the correlator.
// Optional REFERENCE_READER_CONTINUOUS_EN: repeat sweeps until `stop`, ending at a sweep boundary.
module reference_reader
  import caf_ref_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = REF_I_BITS,
  parameter int q_bits        = REF_Q_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [index_bits-1:0]    start_addr,
`ifdef REFERENCE_READER_CONTINUOUS_EN
  input  logic                     stop,
`endif
  output logic [index_bits-1:0]    m_axi_raddr,
  output logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  input  logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic signed [i_bits-1:0] i_in,
  input  logic signed [q_bits-1:0] q_in,
  output logic signed [i_bits-1:0] out_i,
  output logic signed [q_bits-1:0] out_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int entry_w = 1 + i_bits + q_bits;
  localparam int cnt_w   = $clog2(REF_FIFO_DEPTH+1);
  localparam logic [index_bits-1:0] last_index = index_bits'(buffer_length-1);

  ref_state_t            state;
  ref_state_t            state_nxt;
  logic [index_bits-1:0] addr;
  logic [index_bits-1:0] issue_cnt;
  logic [index_bits-1:0] start_idx;
  logic                  pend;
  logic                  pend_last;
  logic                  fire;
  logic                  pop;
  logic                  sweep_end;
  logic                  last_sweep;
  logic                  start_ok;
  logic [cnt_w-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [entry_w-1:0]    head;
  int                    occupancy;

  assign start_ok  = start && (state == IDLE);
  assign start_idx = (int'(start_addr) >= buffer_length) ? '0 : start_addr;

  // Entries held plus the one in flight, less the one leaving this cycle.
  assign occupancy    = int'(fifo_count) + int'(pend) - int'(pop);
  assign m_axi_rvalid = (state == ISSUE) && (occupancy < REF_FIFO_DEPTH);
  assign m_axi_raddr  = addr;
  assign m_axi_rready = pend;
  assign fire         = m_axi_rvalid;
  assign sweep_end    = fire && (issue_cnt == last_index);

`ifdef REFERENCE_READER_CONTINUOUS_EN
  logic stop_req;

  assign last_sweep = stop_req || stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              stop_req <= 1'b0;
    else if (state == IDLE)  stop_req <= 1'b0;
    else if (stop)           stop_req <= 1'b1;
  end
`else
  assign last_sweep = 1'b1;
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign {out_last, out_i, out_q} = head;
  assign busy      = (state == ISSUE) || (state == DRAIN);

  reference_reader_fifo #(
    .width (entry_w)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (pend),
    .wr_data ({pend_last, i_in, q_in}),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // NOTE: every default is assigned before the case so no path leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (sweep_end && last_sweep) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state updates are non-blocking so every register here sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      issue_cnt <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= fire;
      pend_last <= sweep_end;
      done      <= pop && out_last;
      // Sticky: a response missing when due, or a request the buffer was not ready for.
      if ((pend && !s_axi_rvalid) || (fire && !s_axi_rready)) err <= 1'b1;
      if (start_ok) begin
        addr      <= start_idx;
        issue_cnt <= '0;
      end else if (fire) begin
        addr      <= (addr == last_index) ? '0 : addr + index_bits'(1);
        issue_cnt <= sweep_end ? '0 : issue_cnt + index_bits'(1);
      end
    end
  end

endmodule

// File: tb/tb_reference_reader.sv
// Self-checking bench for reference_reader: buffer responder, sweep-level model, directed tests.
// Build with REFERENCE_READER_CONTINUOUS_EN to add the multi-sweep stop test.
module tb_reference_reader;
  import caf_ref_pkg::*;

  localparam int BL = 10;
  localparam int IB = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [IB-1:0]        start_addr = '0;
  logic [IB-1:0]        m_axi_raddr;
  logic                 m_axi_rvalid;
  logic                 m_axi_rready;
  logic                 s_axi_rvalid = 1'b0;
  logic                 s_axi_rready = 1'b1;
  logic signed [11:0]   i_in = '0;
  logic signed [11:0]   q_in = '0;
  logic signed [11:0]   out_i;
  logic signed [11:0]   out_q;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic                 err;
`ifdef REFERENCE_READER_CONTINUOUS_EN
  logic                 stop = 1'b1;
`endif

  reference_reader #(
    .buffer_length (BL),
    .index_bits    (IB),
    .i_bits        (12),
    .q_bits        (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
`ifdef REFERENCE_READER_CONTINUOUS_EN
    .stop         (stop),
`endif
    .m_axi_raddr  (m_axi_raddr),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .i_in         (i_in),
    .q_in         (q_in),
    .out_i        (out_i),
    .out_q        (out_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Reference buffer contents.
  function automatic logic signed [11:0] buf_i(input int idx);
    return 12'(idx * 100 - 450);
  endfunction
  function automatic logic signed [11:0] buf_q(input int idx);
    return 12'(300 - idx * 37);
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Buffer responder and per-cycle input driver.
  int       cyc = 0;
  int       rdy_mode = 0;
  logic     drop_resp = 1'b0;
  logic     req_q = 1'b0;
  logic [IB-1:0] req_addr_q = '0;

  always @(negedge clk) begin
    req_q      = rst_n && m_axi_rvalid;
    req_addr_q = m_axi_raddr;
  end

  always @(posedge clk) begin
    logic v;
    logic [IB-1:0] a;
    int rm;
    cyc++;
    v  = req_q && !drop_resp;
    a  = req_addr_q;
    rm = rdy_mode;
    #1;
    s_axi_rvalid = v;
    i_in         = buf_i(int'(a));
    q_in         = buf_q(int'(a));
    out_ready    = (rm == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  end

  // Sweep-level model: expected address and sample streams.
  ref_sample_t   exp_q[$];
  logic [IB-1:0] exp_addr_q[$];
  ref_sample_t   held_s;
  ref_sample_t   e;
  logic          held = 1'b0;
  logic          busy_exp = 1'b0;
  logic          done_exp = 1'b0;
  logic          busy_next;
  logic          done_next;
  logic          stop_seen = 1'b0;
  int            sweep_start = 0;
  int            issued = 0;
  int            accepted = 0;
  int            done_cnt = 0;

  task automatic push_sweep(input int s);
    ref_sample_t x;
    for (int k = 0; k < BL; k++) begin
      int idx;
      idx = (s + k) % BL;
      exp_addr_q.push_back(IB'(idx));
      x.last = (k == BL - 1);
      x.i    = buf_i(idx);
      x.q    = buf_q(idx);
      exp_q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr_q.delete();
      busy_exp  = 1'b0;
      done_exp  = 1'b0;
      held      = 1'b0;
      stop_seen = 1'b0;
      issued    = 0;
      accepted  = 0;
    end else begin
      check("done", done, done_exp);
      check("busy", busy, busy_exp);
      if (done) done_cnt++;
      busy_next = busy_exp;
      done_next = 1'b0;
`ifdef REFERENCE_READER_CONTINUOUS_EN
      if (stop && busy_exp) stop_seen = 1'b1;
`endif
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_i", out_i, held_s.i);
        check("stall_q", out_q, held_s.q);
        check("stall_last", out_last, held_s.last);
      end
      if (m_axi_rvalid) begin
        issued++;
        if (exp_addr_q.size() == 0) check("unexpected_req", 1, 0);
        else check("raddr", m_axi_raddr, int'(exp_addr_q.pop_front()));
`ifdef REFERENCE_READER_CONTINUOUS_EN
        if (exp_addr_q.size() == 0 && !stop_seen && busy_exp) push_sweep(sweep_start);
`endif
      end
      if (out_valid && out_ready) begin
        accepted++;
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_i", out_i, e.i);
          check("out_q", out_q, e.q);
          check("out_last", out_last, e.last);
          if (e.last) begin
            done_next = 1'b1;
            if (exp_q.size() == 0) busy_next = 1'b0;
          end
        end
      end
      check("inflight", (issued - accepted <= 2), 1);
      if (start && !busy_exp && !done_exp) begin
        sweep_start = (int'(start_addr) >= BL) ? 0 : int'(start_addr);
        stop_seen   = 1'b0;
        push_sweep(sweep_start);
        busy_next   = 1'b1;
      end
      held     = out_valid && !out_ready;
      held_s   = '{last: out_last, i: out_i, q: out_q};
      busy_exp = busy_next;
      done_exp = done_next;
    end
  end

  // Stimulus helpers; inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_last", out_last, 0);
    check("rst_rvalid", m_axi_rvalid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_raddr", m_axi_raddr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start(input int addr, output int s_cyc);
    tick(1);
    start      = 1'b1;
    start_addr = IB'(addr);
    s_cyc      = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check("timeout_done", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, d0, n;

    // Test 1: sweep from 0 at full rate.
    do_reset();
    pulse_start(0, s);
    @(negedge clk);
    check("t1_first_req", m_axi_rvalid, 1);
    check("t1_first_raddr", m_axi_raddr, 0);
    @(negedge clk);
    check("t1_no_out_yet", out_valid, 0);
    @(negedge clk);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_i", out_i, -450);
    check("t1_first_q", out_q, 300);
    check("t1_first_last", out_last, 0);
    wait_done(60, d);
    check("t1_done_latency", d - s, 13);
    tick(2);
    check("t1_drained", exp_q.size(), 0);
    check("t1_err", err, 0);

    // Test 2: sweep from 7 wraps through 9 -> 0.
    pulse_start(7, s);
    @(negedge clk);
    check("t2_first_raddr", m_axi_raddr, 7);
    @(negedge clk);
    @(negedge clk);
    check("t2_first_i", out_i, 250);
    check("t2_first_q", out_q, 41);
    wait_done(60, d);
    check("t2_done_latency", d - s, 13);

    // Out-of-range start index is treated as 0.
    pulse_start(12, s);
    @(negedge clk);
    check("t2b_first_raddr", m_axi_raddr, 0);
    wait_done(60, d);
    tick(2);
    check("t2_drained", exp_q.size(), 0);

    // Test 3: consumer back-pressure 1,0,0,1.
    rdy_mode = 1;
    d0 = done_cnt;
    pulse_start(3, s);
    wait_done(200, d);
    rdy_mode = 0;
    tick(3);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_drained", exp_q.size(), 0);

    // Test 4: reset at the 5th sample, then a clean sweep.
    d0 = done_cnt;
    pulse_start(0, s);
    n = 0;
    for (int k = 0; k < 50 && n < 5; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    check("t4_reached_5", n, 5);
    #2;
    do_reset();
    tick(5);
    check("t4_no_done", done_cnt - d0, 0);
    pulse_start(5, s);
    wait_done(60, d);
    check("t4_done_latency", d - s, 13);
    tick(2);
    check("t4_drained", exp_q.size(), 0);

    // Test 5: start while busy and in the DONE cycle are both ignored.
    d0 = done_cnt;
    pulse_start(0, s);
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(s + 13 - cyc);
    start = 1'b1;
    @(negedge clk);
    check("t5_done_cycle", done, 1);
    tick(1);
    start = 1'b0;
    tick(20);
    check("t5_one_done", done_cnt - d0, 1);
    check("t5_idle", busy, 0);
    check("t5_drained", exp_q.size(), 0);

    // Missing response raises the sticky error; data still flows.
    check("t7_err_before", err, 0);
    pulse_start(0, s);
    tick(2);
    drop_resp = 1'b1;
    tick(1);
    drop_resp = 1'b0;
    wait_done(60, d);
    tick(2);
    check("t7_err_set", err, 1);
    check("t7_drained", exp_q.size(), 0);

`ifdef REFERENCE_READER_CONTINUOUS_EN
    // Test 6: three sweeps, stop raised during the third.
    do_reset();
    stop = 1'b0;
    pulse_start(0, s);
    wait_done(60, d);
    check("t6_done1", d - s, 13);
    wait_done(60, d);
    check("t6_done2", d - s, 23);
    tick(3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_done(60, d);
    check("t6_done3", d - s, 33);
    tick(20);
    check("t6_samples", accepted, 30);
    check("t6_idle", busy, 0);
    stop = 1'b1;
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
